uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//  Receive-side frame parser for the UART link: consumes bytes from UART_RX,
//  hunts for the 5-byte frame HDR0 HDR1 ADDR_H ADDR_L DATA (FA F1 00 01 dd),
//  and presents the payload byte with a 1-cycle valid strobe. It sits between
//  UART_RX and the IR/application logic on the receiving board, and reports
//  address mismatches and inter-byte timeouts.
// PARAMETERS
//  HDR0         8'hFA    first header byte
//  HDR1         8'hF1    second header byte
//  MY_ADDR      16'h0001 expected address, ADDR_H first
//  TIMEOUT_CYC  500000   max clk cycles between bytes inside a frame (10 ms @ 50 MHz)
//  CNT_W        20       timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-low reset
//  i_rdat       in   8      received byte from UART_RX
//  i_rvalid     in   1      1-cycle strobe; i_rdat valid this cycle
//  o_data       out  8      payload byte of the last good frame (held until the next good frame)
//  o_valid      out  1      1-cycle strobe: o_data updated
//  o_addr_err   out  1      1-cycle strobe: header ok, address != MY_ADDR
//  o_timeout    out  1      1-cycle strobe: frame abandoned on inter-byte timeout
//  o_busy       out  1      1 when state != S_HUNT
//  o_frame_cnt  out  16     count of good frames; wraps FFFF->0000
// BEHAVIOUR
//  Reset (rst=0, async): state=S_HUNT, o_data=0, o_valid=0, o_addr_err=0,
//   o_timeout=0, o_busy=0, o_frame_cnt=0, timeout counter=0, addr latch=0.
//  All outputs are registered. Strobes are high for exactly one cycle.
//  A byte is accepted only in a cycle with i_rvalid=1; i_rdat is ignored otherwise.
//  States and transitions (on an accepted byte b):
//   S_HUNT : b==HDR0 -> S_HDR1; else stay.
//   S_HDR1 : b==HDR1 -> S_ADDRH; b==HDR0 -> stay S_HDR1 (resync); else -> S_HUNT.
//            No error strobe in either mismatch case.
//   S_ADDRH: latch addr[15:8]=b -> S_ADDRL (any value).
//   S_ADDRL: {addr[15:8],b}==MY_ADDR -> S_DATA; else pulse o_addr_err -> S_SKIP.
//   S_DATA : o_data<=b, o_valid<=1, o_frame_cnt+=1 -> S_HUNT.
//   S_SKIP : discard b (keeps a payload of 8'hFA from being read as a header) -> S_HUNT.
//  Latency: o_valid rises on the clk edge after the cycle in which DATA is accepted.
//  Timeout: the counter clears on every accepted byte and is held at 0 in S_HUNT.
//   In any other state it increments each cycle without i_rvalid. When it
//   reaches TIMEOUT_CYC: pulse o_timeout, go to S_HUNT, clear the counter.
//   A byte accepted in the same cycle the count would hit TIMEOUT_CYC wins:
//   the byte is processed and no timeout is raised.
//  o_addr_err and o_timeout are never asserted in the same cycle.
//  Back-to-back frames with no idle gap are supported: the HDR0 of the next
//   frame is accepted in S_HUNT on the cycle after DATA.
//  Async reset mid-frame drops the partial frame; no strobe is emitted.
// TESTING
//  1. Bytes FA F1 00 01 5A -> one o_valid pulse, o_data=8'h5A, o_frame_cnt=1, no error strobes.
//  2. FA FA F1 00 01 33 -> resync in S_HDR1; o_valid with o_data=8'h33.
//  3. FA F1 00 02 FA, then FA F1 00 01 77 -> o_addr_err pulses once; the FA payload
//     is skipped; the second frame gives o_valid with 8'h77.
//  4. FA F1 00, then idle TIMEOUT_CYC cycles -> o_timeout pulses once, o_busy=0.
//     Then 01 5A -> no o_valid.
//  5. Two frames back-to-back (...01 11 FA F1 00 01 22) -> o_valid twice (11, 22),
//     o_frame_cnt=2. Also preload o_frame_cnt=FFFF and send one frame -> 0000.
//  6. Assert rst low after FA F1 00 -> all outputs return to reset values.
//     Then 01 5A -> no o_valid; a full frame afterwards decodes normally.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Hunts FA F1 ADDR_H ADDR_L DATA frames on the UART byte stream; payload strobed 1 cycle after DATA.
// No backpressure: every i_rvalid byte is consumed; stalls inside a frame end in a timeout.
module uart_frame_rx #(
    parameter logic [7:0]  HDR0        = 8'hFA,
    parameter logic [7:0]  HDR1        = 8'hF1,
    parameter logic [15:0] MY_ADDR     = 16'h0001,
    parameter int          TIMEOUT_CYC = 500000,
    parameter int          CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rdat,
    input  logic        i_rvalid,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_addr_err,
    output logic        o_timeout,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        S_HUNT, S_HDR1, S_ADDRH, S_ADDRL, S_DATA, S_SKIP
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       addr_h;

    // o_busy is written alongside every state change so it always mirrors state != S_HUNT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_HUNT;
            tmo_cnt     <= '0;
            addr_h      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_addr_err  <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_addr_err <= 1'b0;
            o_timeout  <= 1'b0;
            if (i_rvalid) begin
                tmo_cnt <= '0;
                case (state)
                    S_HUNT: begin
                        if (i_rdat == HDR0) begin
                            state  <= S_HDR1;
                            o_busy <= 1'b1;
                        end
                    end
                    S_HDR1: begin
                        if (i_rdat == HDR1) begin
                            state <= S_ADDRH;
                        end else if (i_rdat != HDR0) begin
                            state  <= S_HUNT;
                            o_busy <= 1'b0;
                        end
                    end
                    S_ADDRH: begin
                        addr_h <= i_rdat;
                        state  <= S_ADDRL;
                    end
                    S_ADDRL: begin
                        if ({addr_h, i_rdat} == MY_ADDR) begin
                            state <= S_DATA;
                        end else begin
                            o_addr_err <= 1'b1;
                            state      <= S_SKIP;
                        end
                    end
                    S_DATA: begin
                        o_data      <= i_rdat;
                        o_valid     <= 1'b1;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        state       <= S_HUNT;
                        o_busy      <= 1'b0;
                    end
                    default: begin
                        state  <= S_HUNT;
                        o_busy <= 1'b0;
                    end
                endcase
            end else if (state != S_HUNT) begin
                if (tmo_cnt == TMO_LAST) begin
                    o_timeout <= 1'b1;
                    state     <= S_HUNT;
                    o_busy    <= 1'b0;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed table, hand-written corner sequences, random traffic vs reference model.
module tb_uart_frame_rx;

    localparam logic [7:0]  HDR0 = 8'hFA;
    localparam logic [7:0]  HDR1 = 8'hF1;
    localparam logic [15:0] MY_ADDR = 16'h0001;
    localparam int          T = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_rdat = 8'h00;
    logic        i_rvalid = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid, o_addr_err, o_timeout, o_busy;
    logic [15:0] o_frame_cnt;

    uart_frame_rx #(.HDR0(HDR0), .HDR1(HDR1), .MY_ADDR(MY_ADDR), .TIMEOUT_CYC(T), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .i_rdat(i_rdat), .i_rvalid(i_rvalid),
        .o_data(o_data), .o_valid(o_valid), .o_addr_err(o_addr_err),
        .o_timeout(o_timeout), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame progress as a count of matched bytes (5 = discarding a payload).
    int          m_pos, m_idle;
    logic [7:0]  m_ah, m_data;
    logic [15:0] m_cnt;
    logic        m_valid, m_aerr, m_to;

    typedef struct {
        logic        rv;
        logic [7:0]  dat;
        logic        ev, ea, eb;
        logic [7:0]  ed;
        logic [15:0] ec;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_idle = 0; m_ah = 0; m_data = 0; m_cnt = 0;
        m_valid = 0; m_aerr = 0; m_to = 0;
    endtask

    task automatic model(input logic rv, input logic [7:0] b);
        m_valid = 0; m_aerr = 0; m_to = 0;
        if (rv) begin
            m_idle = 0;
            case (m_pos)
                0: if (b == HDR0) m_pos = 1;
                1: if (b == HDR1) m_pos = 2; else if (b != HDR0) m_pos = 0;
                2: begin m_ah = b; m_pos = 3; end
                3: if ({m_ah, b} == MY_ADDR) m_pos = 4; else begin m_aerr = 1; m_pos = 5; end
                4: begin m_data = b; m_valid = 1; m_cnt = m_cnt + 16'd1; m_pos = 0; end
                default: m_pos = 0;
            endcase
        end else if (m_pos != 0) begin
            m_idle++;
            if (m_idle == T) begin m_to = 1; m_pos = 0; m_idle = 0; end
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("addr_err", 32'(o_addr_err), 32'(m_aerr));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        chk("busy", 32'(o_busy), 32'(m_pos != 0));
        chk("data", 32'(o_data), 32'(m_data));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic rv, input logic [7:0] b);
        i_rvalid = rv;
        i_rdat   = b;
        model(rv, b);
        @(posedge clk);
        #1;
        check_model();
        i_rvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a_l, input logic [7:0] d);
        step(1, HDR0); step(1, HDR1); step(1, 8'h00); step(1, a_l); step(1, d);
    endtask

    task automatic add(input logic rv, input logic [7:0] dat, input logic ev, input logic ea,
                       input logic eb, input logic [7:0] ed, input logic [15:0] ec);
        vec_t v;
        v.rv = rv; v.dat = dat; v.ev = ev; v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
        tbl.push_back(v);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 5))
            0, 1: return HDR0;
            2:    return HDR1;
            3:    return 8'h00;
            4:    return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return $urandom_range(T - 1, T + 1);
        if (r < 12) return 0;
        return $urandom_range(1, 3);
    endfunction

    initial begin
        logic [7:0] fr[5];
        int g;

        model_reset();
        #2;
        chk("reset_data", 32'(o_data), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        chk("reset_cnt", 32'(o_frame_cnt), 32'h0);
        chk("reset_strobes", 32'({o_valid, o_addr_err, o_timeout}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic frame, resync, address error with FA payload, idle, back-to-back.
        add(1, 8'hFA, 0, 0, 1, 8'h00, 0); add(1, 8'hF1, 0, 0, 1, 8'h00, 0);
        add(1, 8'h00, 0, 0, 1, 8'h00, 0); add(1, 8'h01, 0, 0, 1, 8'h00, 0);
        add(1, 8'h5A, 1, 0, 0, 8'h5A, 1);
        add(1, 8'hFA, 0, 0, 1, 8'h5A, 1); add(1, 8'hFA, 0, 0, 1, 8'h5A, 1);
        add(1, 8'hF1, 0, 0, 1, 8'h5A, 1); add(1, 8'h00, 0, 0, 1, 8'h5A, 1);
        add(1, 8'h01, 0, 0, 1, 8'h5A, 1); add(1, 8'h33, 1, 0, 0, 8'h33, 2);
        add(1, 8'hFA, 0, 0, 1, 8'h33, 2); add(1, 8'hF1, 0, 0, 1, 8'h33, 2);
        add(1, 8'h00, 0, 0, 1, 8'h33, 2); add(1, 8'h02, 0, 1, 1, 8'h33, 2);
        add(1, 8'hFA, 0, 0, 0, 8'h33, 2);
        add(1, 8'hFA, 0, 0, 1, 8'h33, 2); add(1, 8'hF1, 0, 0, 1, 8'h33, 2);
        add(1, 8'h00, 0, 0, 1, 8'h33, 2); add(1, 8'h01, 0, 0, 1, 8'h33, 2);
        add(1, 8'h77, 1, 0, 0, 8'h77, 3);
        add(0, 8'hFA, 0, 0, 0, 8'h77, 3);
        add(1, 8'hFA, 0, 0, 1, 8'h77, 3); add(1, 8'hF1, 0, 0, 1, 8'h77, 3);
        add(1, 8'h00, 0, 0, 1, 8'h77, 3); add(1, 8'h01, 0, 0, 1, 8'h77, 3);
        add(1, 8'h11, 1, 0, 0, 8'h11, 4);
        add(1, 8'hFA, 0, 0, 1, 8'h11, 4); add(1, 8'hF1, 0, 0, 1, 8'h11, 4);
        add(1, 8'h00, 0, 0, 1, 8'h11, 4); add(1, 8'h01, 0, 0, 1, 8'h11, 4);
        add(1, 8'h22, 1, 0, 0, 8'h22, 5);

        foreach (tbl[i]) begin
            step(tbl[i].rv, tbl[i].dat);
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_aerr", i), 32'(o_addr_err), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_cnt", i), 32'(o_frame_cnt), 32'(tbl[i].ec));
        end

        // Inter-byte timeout, then the stranded tail must not decode.
        step(1, 8'hFA); step(1, 8'hF1); step(1, 8'h00);
        for (int i = 1; i <= T; i++) step(0, 8'hFA);
        chk("to_pulse", 32'(o_timeout), 32'h1);
        chk("to_busy", 32'(o_busy), 32'h0);
        step(0, 8'h00);
        chk("to_single", 32'(o_timeout), 32'h0);
        step(1, 8'h01); step(1, 8'h5A);
        chk("to_tail_valid", 32'(o_valid), 32'h0);

        // A byte arriving on the timeout cycle wins.
        step(1, 8'hFA); step(1, 8'hF1);
        for (int i = 1; i < T; i++) step(0, 8'h00);
        step(1, 8'h00);
        chk("edge_no_to", 32'(o_timeout), 32'h0);
        chk("edge_busy", 32'(o_busy), 32'h1);
        step(1, 8'h01); step(1, 8'h5A);
        chk("edge_valid", 32'(o_valid), 32'h1);

        // Frame counter wrap.
        force dut.o_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(0, 8'h00);
        release dut.o_frame_cnt;
        send_frame(8'h01, 8'hC3);
        chk("wrap_cnt", 32'(o_frame_cnt), 32'h0);
        chk("wrap_valid", 32'(o_valid), 32'h1);

        // Async reset mid-frame.
        step(1, 8'hFA); step(1, 8'hF1); step(1, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_data", 32'(o_data), 32'h0);
        chk("arst_busy", 32'(o_busy), 32'h0);
        chk("arst_cnt", 32'(o_frame_cnt), 32'h0);
        chk("arst_strobes", 32'({o_valid, o_addr_err, o_timeout}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1, 8'h01); step(1, 8'h5A);
        chk("arst_tail_valid", 32'(o_valid), 32'h0);
        send_frame(8'h01, 8'hA5);
        chk("arst_frame_valid", 32'(o_valid), 32'h1);
        chk("arst_frame_data", 32'(o_data), 32'hA5);

        // Random traffic: well-formed frames mixed with junk bytes and gaps.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                fr[0] = HDR0; fr[1] = HDR1; fr[2] = 8'h00;
                fr[3] = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01;
                fr[4] = ($urandom_range(0, 4) == 0) ? HDR0 : 8'($urandom);
            end else begin
                for (int k = 0; k < 5; k++) fr[k] = rand_byte();
            end
            for (int k = 0; k < 5; k++) begin
                step(1, fr[k]);
                g = pick_gap();
                for (int j = 0; j < g; j++) step(0, rand_byte());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
